// File: rtl/gyruss_audio_pkg.sv
// Gyruss audio output stage: shared constants, sample types
// and small arithmetic helpers.
package gyruss_audio_pkg;
  localparam int SLOTS_PER_FRAME = 64;
  localparam int SLOT_L_MSB = 1;
  localparam int SLOT_R_MSB = 33;
  localparam int SAMPLE_W = 16;
  localparam int DCB_W = 18;

  typedef logic [SAMPLE_W-1:0] samp_t;
  typedef logic signed [DCB_W-1:0] dcb_t;

  function automatic samp_t sat16(input logic signed [DCB_W:0] v);
    samp_t r;
    if (v > 19'sd32767) r = 16'h7fff;
    else if (v < -19'sd32768) r = 16'h8000;
    else r = v[SAMPLE_W-1:0];
    return r;
  endfunction

  // offset-binary mix sample to signed, widened to DC-state width
  function automatic dcb_t off2s(input samp_t x);
    return dcb_t'({{(DCB_W-SAMPLE_W+1){~x[SAMPLE_W-1]}},
                   x[SAMPLE_W-2:0]});
  endfunction
endpackage

// File: rtl/gyruss_audio_if.sv
// Mixer-side and output-side signals of the Gyruss audio
// output stage, grouped for the master (mixer) and slave (stage).
interface gyruss_audio_if;
  import gyruss_audio_pkg::*;

  samp_t SND_L;
  samp_t SND_R;
  logic [2:0] VOL;
  logic MUTE;
  logic BYPASS;
  samp_t PCM_L;
  samp_t PCM_R;
  logic PCM_STB;
  logic I2S_BCLK;
  logic I2S_LRCK;
  logic I2S_DATA;

  modport master (
    output SND_L, SND_R, VOL, MUTE, BYPASS,
    input PCM_L, PCM_R, PCM_STB,
    input I2S_BCLK, I2S_LRCK, I2S_DATA
  );

  modport slave (
    input SND_L, SND_R, VOL, MUTE, BYPASS,
    output PCM_L, PCM_R, PCM_STB,
    output I2S_BCLK, I2S_LRCK, I2S_DATA
  );
endinterface

// File: rtl/gyruss_i2s_tx.sv
// I2S transmitter: BCLK divider, 64-slot frame counter,
// word select and per-channel 16-bit shifters.
module gyruss_i2s_tx
  import gyruss_audio_pkg::*;
#(
  parameter int BCLK_HALF = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  samp_t pcm_l,
  input  samp_t pcm_r,
  output logic  frame_tick,
  output logic  bclk,
  output logic  lrck,
  output logic  sdata
);
  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int SW = $clog2(SLOTS_PER_FRAME);
  localparam logic [DW-1:0] DIV_TC = DW'(BCLK_HALF - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS_PER_FRAME - 1);
  localparam logic [SW-1:0] SLOT_L = SW'(SLOT_L_MSB);
  localparam logic [SW-1:0] SLOT_R = SW'(SLOT_R_MSB);

  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] slot_q, slot_d;
  logic bclk_q, bclk_d;
  logic tick_q, tick_d;
  samp_t shl_q, shl_d;
  samp_t shr_q, shr_d;

  always_comb begin
    div_d = div_q + 1'b1;
    slot_d = slot_q;
    bclk_d = bclk_q;
    tick_d = 1'b0;
    shl_d = shl_q;
    shr_d = shr_q;
    if (div_q == DIV_TC) begin
      div_d = '0;
      bclk_d = ~bclk_q;
      // slot and data advance only on the falling toggle
      if (bclk_q) begin
        slot_d = slot_q + 1'b1;
        tick_d = (slot_q == SLOT_LAST);
        shl_d = shl_q << 1;
        shr_d = shr_q << 1;
        if (slot_d == SLOT_L) shl_d = pcm_l;
        if (slot_d == SLOT_R) shr_d = pcm_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      slot_q <= '0;
      bclk_q <= 1'b0;
      tick_q <= 1'b0;
      shl_q <= '0;
      shr_q <= '0;
    end else begin
      div_q <= div_d;
      slot_q <= slot_d;
      bclk_q <= bclk_d;
      tick_q <= tick_d;
      shl_q <= shl_d;
      shr_q <= shr_d;
    end
  end

  assign frame_tick = tick_q;
  assign bclk = bclk_q;
  assign lrck = slot_q[SW-1];
  assign sdata = slot_q[SW-1] ? shr_q[SAMPLE_W-1]
                              : shl_q[SAMPLE_W-1];
endmodule

// File: rtl/gyruss_audio_out.sv
// Gyruss audio output stage: per-frame DC blocker, volume,
// mute and saturation feeding PCM and I2S outputs.
module gyruss_audio_out
  import gyruss_audio_pkg::*;
#(
  parameter int BCLK_HALF = 8,
  parameter int DCB_SHIFT = 10
) (
  input logic MCLK,
  input logic RESET_N,
  gyruss_audio_if.slave aud
);
  logic tick;
  logic v1_q, v1_d, v2_q, v2_d;
  logic stb_q, stb_d, init_q, init_d;
  samp_t xl_q, xl_d, xr_q, xr_d;
  samp_t xpl_q, xpl_d, xpr_q, xpr_d;
  samp_t pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  dcb_t yl_q, yl_d, yr_q, yr_d;
  dcb_t sl_q, sl_d, sr_q, sr_d;

  function automatic dcb_t dc_next(input samp_t x, input samp_t xp,
                                   input dcb_t y);
    dcb_t xs, ps;
    xs = dcb_t'({{(DCB_W-SAMPLE_W){1'b0}}, x});
    ps = dcb_t'({{(DCB_W-SAMPLE_W){1'b0}}, xp});
    return xs - ps + y - (y >>> DCB_SHIFT);
  endfunction

  function automatic samp_t vol_out(input dcb_t s,
                                    input logic [2:0] vol,
                                    input logic mute);
    logic signed [DCB_W:0] v;
    if (mute) v = '0;
    else v = $signed({s[DCB_W-1], s}) >>> vol;
    return sat16(v);
  endfunction

  always_comb begin
    v1_d = tick;
    v2_d = v1_q;
    stb_d = v2_q;
    init_d = init_q;
    xl_d = xl_q;
    xr_d = xr_q;
    xpl_d = xpl_q;
    xpr_d = xpr_q;
    yl_d = yl_q;
    yr_d = yr_q;
    sl_d = sl_q;
    sr_d = sr_q;
    pcm_l_d = pcm_l_q;
    pcm_r_d = pcm_r_q;
    if (tick) begin
      xl_d = aud.SND_L;
      xr_d = aud.SND_R;
    end
    // DC state runs every frame, even in bypass, so toggling is clean
    if (v1_q) begin
      if (init_q) begin
        yl_d = '0;
        yr_d = '0;
      end else begin
        yl_d = dc_next(xl_q, xpl_q, yl_q);
        yr_d = dc_next(xr_q, xpr_q, yr_q);
      end
      xpl_d = xl_q;
      xpr_d = xr_q;
      init_d = 1'b0;
      sl_d = aud.BYPASS ? off2s(xl_q) : yl_d;
      sr_d = aud.BYPASS ? off2s(xr_q) : yr_d;
    end
    if (v2_q) begin
      pcm_l_d = vol_out(sl_q, aud.VOL, aud.MUTE);
      pcm_r_d = vol_out(sr_q, aud.VOL, aud.MUTE);
    end
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      stb_q <= 1'b0;
      init_q <= 1'b1;
      xl_q <= '0;
      xr_q <= '0;
      xpl_q <= '0;
      xpr_q <= '0;
      yl_q <= '0;
      yr_q <= '0;
      sl_q <= '0;
      sr_q <= '0;
      pcm_l_q <= '0;
      pcm_r_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      stb_q <= stb_d;
      init_q <= init_d;
      xl_q <= xl_d;
      xr_q <= xr_d;
      xpl_q <= xpl_d;
      xpr_q <= xpr_d;
      yl_q <= yl_d;
      yr_q <= yr_d;
      sl_q <= sl_d;
      sr_q <= sr_d;
      pcm_l_q <= pcm_l_d;
      pcm_r_q <= pcm_r_d;
    end
  end

  gyruss_i2s_tx #(.BCLK_HALF(BCLK_HALF)) u_tx (
    .clk(MCLK),
    .rst_n(RESET_N),
    .pcm_l(pcm_l_q),
    .pcm_r(pcm_r_q),
    .frame_tick(tick),
    .bclk(aud.I2S_BCLK),
    .lrck(aud.I2S_LRCK),
    .sdata(aud.I2S_DATA)
  );

  assign aud.PCM_L = pcm_l_q;
  assign aud.PCM_R = pcm_r_q;
  assign aud.PCM_STB = stb_q;
endmodule

// File: tb/tb_gyruss_audio_out.sv
// Bench for gyruss_audio_out: frame-level reference model checked
// every MCLK, plus hand-computed expectations at key points.
module tb_gyruss_audio_out;
  logic mclk = 1'b0;
  logic rst_n = 1'b1;
  bit run = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  int pl_h[16];
  int pr_h[16];
  int m_xp[2];
  int m_y[2];
  bit m_init = 1'b1;

  gyruss_audio_if aif();

  gyruss_audio_out #(.BCLK_HALF(8), .DCB_SHIFT(10)) dut (
    .MCLK(mclk),
    .RESET_N(rst_n),
    .aud(aif.slave)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cyc %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic int fdiv(input int a, input int k);
    int d;
    d = 1 << k;
    return (a >= 0) ? a / d : -((-a + d - 1) / d);
  endfunction

  task automatic model_ch(input int ch, input int x, output int pcm);
    int s;
    int v;
    if (m_init) begin
      m_xp[ch] = x;
      m_y[ch] = 0;
    end else begin
      m_y[ch] = x - m_xp[ch] + m_y[ch] - fdiv(m_y[ch], 10);
      m_xp[ch] = x;
    end
    s = aif.BYPASS ? x - 32768 : m_y[ch];
    v = aif.MUTE ? 0 : fdiv(s, int'(aif.VOL));
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    pcm = v & 32'hffff;
  endtask

  always @(negedge mclk) begin : cmp
    int f, o, sl, lf, dl;
    if (run && !rst_n) begin
      m_init = 1'b1;
      for (int i = 0; i < 16; i++) begin
        pl_h[i] = 0;
        pr_h[i] = 0;
      end
      chk("rst_pcm_l", aif.PCM_L, 0);
      chk("rst_pcm_r", aif.PCM_R, 0);
      chk("rst_stb", aif.PCM_STB, 0);
      chk("rst_bclk", aif.I2S_BCLK, 0);
      chk("rst_lrck", aif.I2S_LRCK, 0);
      chk("rst_data", aif.I2S_DATA, 0);
    end else if (run) begin
      f = cyc / 1024;
      o = cyc % 1024;
      if (o == 2 && f >= 1 && f < 16) begin
        model_ch(0, int'(aif.SND_L), pl_h[f]);
        model_ch(1, int'(aif.SND_R), pr_h[f]);
        m_init = 1'b0;
      end
      lf = (o >= 3) ? f : f - 1;
      if (lf < 0 || lf > 15) lf = 0;
      chk("pcm_l", aif.PCM_L, pl_h[lf]);
      chk("pcm_r", aif.PCM_R, pr_h[lf]);
      chk("pcm_stb", aif.PCM_STB, int'(o == 3 && f >= 1));
      chk("bclk", aif.I2S_BCLK, (cyc / 8) % 2);
      sl = (cyc / 16) % 64;
      chk("lrck", aif.I2S_LRCK, int'(sl >= 32));
      dl = 0;
      if (f >= 1 && f < 16 && sl >= 1 && sl <= 16)
        dl = (pl_h[f] >> (16 - sl)) & 1;
      else if (f >= 1 && f < 16 && sl >= 33 && sl <= 48)
        dl = (pr_h[f] >> (48 - sl)) & 1;
      chk("data", aif.I2S_DATA, dl);
    end
  end

  task automatic at(input int c);
    int g;
    g = 0;
    while (cyc != c && g < 8000) begin
      @(negedge mclk);
      g++;
    end
    if (cyc != c) chk("at_timeout", cyc, c);
  endtask

  task automatic set_in(input logic [15:0] l, input logic [15:0] r,
                        input logic [2:0] v, input logic b,
                        input logic m);
    aif.SND_L = l;
    aif.SND_R = r;
    aif.VOL = v;
    aif.BYPASS = b;
    aif.MUTE = m;
  endtask

  task automatic do_reset();
    @(negedge mclk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_in(16'h8000, 16'h8000, 3'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;

    // timing from release, then DC blocker on a held mid-scale input
    at(7);    chk("bclk_pre_rise", aif.I2S_BCLK, 0);
    at(8);    chk("bclk_first_rise", aif.I2S_BCLK, 1);
    at(511);  chk("lrck_pre_rise", aif.I2S_LRCK, 0);
    at(512);  chk("lrck_first_rise", aif.I2S_LRCK, 1);
    at(1026); chk("stb_t2", aif.PCM_STB, 0);
    at(1027); chk("stb_t3", aif.PCM_STB, 1);
    at(1030); chk("init_pcm_l", aif.PCM_L, 0);
    at(1536); aif.SND_L = 16'h9000;
    at(2051); chk("dc_step", aif.PCM_L, 16'h1000);
    chk("dc_step_r", aif.PCM_R, 0);
    at(3075); chk("dc_decay", aif.PCM_L, 16'h0ffc);

    // bypass: offset-binary to signed
    at(3584);
    set_in(16'hc000, 16'h4000, 3'd0, 1'b1, 1'b0);
    at(4099); chk("byp_l", aif.PCM_L, 16'h4000);
    chk("byp_r", aif.PCM_R, 16'hc000);
    at(4116); chk("i2s_slot1", aif.I2S_DATA, 0);
    at(4132); chk("i2s_slot2", aif.I2S_DATA, 1);
    at(4148); chk("i2s_slot3", aif.I2S_DATA, 0);
    at(4420); chk("i2s_slot20", aif.I2S_DATA, 0);
    at(4628); chk("i2s_slot33", aif.I2S_DATA, 1);
    at(4644); chk("i2s_slot34", aif.I2S_DATA, 1);
    at(4660); chk("i2s_slot35", aif.I2S_DATA, 0);

    // reset in slot 20 while BCLK is high
    at(5452);
    chk("pre_rst_bclk", aif.I2S_BCLK, 1);
    chk("pre_rst_pcm_l", aif.PCM_L, 16'h4000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bclk", aif.I2S_BCLK, 0);
    chk("mid_rst_lrck", aif.I2S_LRCK, 0);
    chk("mid_rst_data", aif.I2S_DATA, 0);
    chk("mid_rst_pcm_l", aif.PCM_L, 0);
    chk("mid_rst_pcm_r", aif.PCM_R, 0);
    chk("mid_rst_stb", aif.PCM_STB, 0);
    set_in(16'h0000, 16'hffff, 3'd0, 1'b0, 1'b0);
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;

    // full-scale steps saturate both ways
    at(1536);
    aif.SND_L = 16'hffff;
    aif.SND_R = 16'h0000;
    at(2051); chk("sat_pos", aif.PCM_L, 16'h7fff);
    chk("sat_neg", aif.PCM_R, 16'h8000);

    // volume 2 on a full-scale step
    set_in(16'h0000, 16'h8000, 3'd2, 1'b0, 1'b0);
    do_reset();
    at(1536); aif.SND_L = 16'hffff;
    at(2051); chk("vol2_step", aif.PCM_L, 16'h3fff);
    at(3075); chk("vol2_decay", aif.PCM_L, 16'h3ff0);

    // step taken while muted keeps decaying in the DC state
    set_in(16'h8000, 16'h8000, 3'd0, 1'b0, 1'b0);
    do_reset();
    at(1536);
    aif.MUTE = 1'b1;
    aif.SND_L = 16'h9000;
    at(2051); chk("mute_pcm_l", aif.PCM_L, 0);
    at(3584); aif.MUTE = 1'b0;
    at(4099); chk("unmute_pcm_l", aif.PCM_L, 16'h0ff9);
    at(5220);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
